ln_mcif_rd_arb: RTL
===================

LN_MCIF_RD_ARB -- requirements
Module: ln_mcif_rd_arb

Interface
REQ-001 SHALL have parameter TAG_DEPTH, default 4: maximum number of outstanding read bursts, power of two, at least 2.
REQ-002 SHALL have port clk, input, 1: the single clock.
REQ-003 SHALL have port rst_n, input, 1: asynchronous active-low reset.
REQ-004 SHALL have ports reqN_vld input 1, reqN_rdy output 1 and reqN_pd input `log2AXI_BURST_LEN+64, for N=0,1: requester N read command {cmd_len, base_addr, offset_addr}. Requester 0 is the LN weight/bias loader; requester 1 is the LN feature reader.
REQ-005 SHALL have ports mcif_rd_req_vld output 1, mcif_rd_req_rdy input 1 and mcif_rd_req_pd output `log2AXI_BURST_LEN+64: the shared MCIF read command.
REQ-006 SHALL have ports mcif_rd_resp_vld input 1, mcif_rd_resp_rdy output 1 and mcif_rd_resp_pd input `MAX_DAT_DW*`Tout: the shared read response.
REQ-007 SHALL have ports respN_vld output 1, respN_rdy input 1 and respN_pd output `MAX_DAT_DW*`Tout, for N=0,1: per-requester response.
REQ-008 SHALL have port mcif_rd_fifo_pop, output, 1: pulses once per accepted response beat.
REQ-009 SHALL have port busy, output, 1: high while a command is held or any burst is outstanding.

Function
REQ-010 SHALL use a two-state command FSM: IDLE and ISSUE.
REQ-011 In IDLE, with at least one reqN_vld and tag count < TAG_DEPTH, the block SHALL capture the winner's pd, pulse that requester's reqN_rdy for exactly this cycle, and move to ISSUE.
REQ-012 SHALL drive reqN_rdy low in ISSUE, while the tag FIFO is full, and for the non-selected requester.
REQ-013 In ISSUE, mcif_rd_req_vld SHALL be 1 and mcif_rd_req_pd SHALL be the captured pd; command latency is one cycle from the rdy pulse to vld.
REQ-014 SHALL hold vld and pd stable in ISSUE until mcif_rd_req_rdy is high. On that handshake it SHALL push the tag {requester id, cmd_len} into the tag FIFO and return to IDLE.
REQ-015 cmd_len SHALL be pd bits [`log2AXI_BURST_LEN+63:64] and SHALL encode beats minus 1.
REQ-016 Arbitration SHALL be round-robin. With both requesters valid, the one not granted last SHALL win. The last-grant pointer SHALL reset to 1, so requester 0 wins the first tie.
REQ-017 Responses SHALL return in command order. Beats SHALL be routed to the requester named by the head tag.
REQ-018 The response path SHALL implement the following:
- mcif_rd_resp_rdy = tag FIFO not empty AND head requester's respN_rdy;
- respN_vld = mcif_rd_resp_vld AND tag FIFO not empty AND head id == N;
- respN_pd = mcif_rd_resp_pd, combinational, zero latency.
REQ-019 A beat counter SHALL count accepted beats. When it equals the head cmd_len, the counter SHALL clear and the head tag SHALL be popped in the same cycle.
REQ-020 mcif_rd_resp_vld with an empty tag FIFO SHALL be stalled (rdy=0) and SHALL NOT be dropped or routed.
REQ-021 A push and pop in the same cycle SHALL leave the count unchanged. This SHALL be allowed when the FIFO is full, but a new grant SHALL still wait for the count to drop.
REQ-022 mcif_rd_fifo_pop = mcif_rd_resp_vld AND mcif_rd_resp_rdy.
REQ-023 busy = (state==ISSUE) OR tag FIFO not empty.

Reset
REQ-024 On rst_n low, the block SHALL reset as follows:
- state IDLE;
- tag FIFO empty, read/write pointers 0;
- beat counter 0;
- last-grant pointer 1;
- all vld/rdy outputs 0, mcif_rd_fifo_pop 0, busy 0, mcif_rd_req_pd 0.
REQ-025 Reset mid-burst SHALL discard all outstanding tags. Re-synchronising the MCIF after such a reset is the system's responsibility.

Configuration
REQ-026 With LN_ARB_FIXED_PRIO_EN defined, requester 0 SHALL always win ties; without it, round-robin per REQ-016 SHALL apply.

Structure
REQ-027 The tag width (1 + `log2AXI_BURST_LEN) and the pd field offsets SHALL be shared constants in CNN_defines.vh.
REQ-028 The tag FIFO SHALL be one sub-module, ln_arb_tag_fifo (TAG_DEPTH x tag width, registered storage, count output).

Verification
REQ-029 Req0 alone with cmd_len=3, mcif rdy tied 1 -> req0_rdy pulses in cycle N; mcif_rd_req_vld in N+1 with pd equal to req0_pd; 4 response beats go to resp0; busy clears after beat 4.
REQ-030 Both requesters valid continuously, 4 grants -> grant order 0,1,0,1. With LN_ARB_FIXED_PRIO_EN -> 0,0,0,0.
REQ-031 mcif_rd_req_rdy held low 5 cycles -> vld and pd stay stable for 5 cycles, and no reqN_rdy pulse occurs.
REQ-032 TAG_DEPTH=4, 4 commands issued and no responses -> a fifth request is stalled until the first burst's last beat, then it is granted.
REQ-033 Interleaved bursts 0(len 1) then 1(len 2) with resp1_rdy low for 3 cycles -> resp0 gets 2 beats; mcif_rd_resp_rdy is low while resp1_rdy is low; resp1 then gets 3 beats; mcif_rd_fifo_pop pulses 5 times.
REQ-034 rst_n asserted mid-burst -> all outputs 0 and busy 0 immediately; the next request is granted normally with the pointer at reset value.

Source files
------------

// File: rtl/ln_mcif_rd_arb_pkg.sv
// rtl/ln_mcif_rd_arb_pkg.sv - shared widths, pd field offsets and types for the LN MCIF read arbiter
// The CNN_defines.vh constants are supplied here so every file of the block sees one definition.
`ifndef log2AXI_BURST_LEN
`define log2AXI_BURST_LEN 4
`endif
`ifndef MAX_DAT_DW
`define MAX_DAT_DW 16
`endif
`ifndef Tout
`define Tout 4
`endif

package ln_mcif_rd_arb_pkg;
  localparam int BL_W    = `log2AXI_BURST_LEN;
  localparam int LEN_LSB = 64;
  localparam int PD_W    = BL_W + LEN_LSB;
  localparam int DAT_W   = `MAX_DAT_DW * `Tout;
  localparam int TAG_W   = 1 + BL_W;

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } state_t;

  typedef struct packed {
    logic            id;
    logic [BL_W-1:0] len;
  } tag_t;
endpackage

// File: rtl/ln_arb_tag_fifo.sv
// rtl/ln_arb_tag_fifo.sv - in-order tag FIFO recording {requester id, cmd_len} per outstanding burst
module ln_arb_tag_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 5
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [W-1:0]             wdata,
  input  logic                     pop,
  output logic [W-1:0]             rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  assign rdata = mem[rd_ptr];
  assign empty = (count == '0);
endmodule

// File: rtl/ln_mcif_rd_arb.sv
// rtl/ln_mcif_rd_arb.sv - two-requester MCIF read command arbiter with in-order response routing
// Define LN_ARB_FIXED_PRIO_EN to make requester 0 win every tie instead of round-robin.
import ln_mcif_rd_arb_pkg::*;

module ln_mcif_rd_arb #(
  parameter int TAG_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_vld,
  output logic             req0_rdy,
  input  logic [PD_W-1:0]  req0_pd,
  input  logic             req1_vld,
  output logic             req1_rdy,
  input  logic [PD_W-1:0]  req1_pd,
  output logic             mcif_rd_req_vld,
  input  logic             mcif_rd_req_rdy,
  output logic [PD_W-1:0]  mcif_rd_req_pd,
  input  logic             mcif_rd_resp_vld,
  output logic             mcif_rd_resp_rdy,
  input  logic [DAT_W-1:0] mcif_rd_resp_pd,
  output logic             resp0_vld,
  input  logic             resp0_rdy,
  output logic [DAT_W-1:0] resp0_pd,
  output logic             resp1_vld,
  input  logic             resp1_rdy,
  output logic [DAT_W-1:0] resp1_pd,
  output logic             mcif_rd_fifo_pop,
  output logic             busy
);
  localparam int CW = $clog2(TAG_DEPTH) + 1;

  state_t          state;
  logic            id_r;
  logic [BL_W-1:0] beat_cnt;
  logic [CW-1:0]   tag_cnt;
  logic            tag_empty;
  logic            tag_full;
  logic            tag_push;
  logic            tag_pop;
  logic [TAG_W-1:0] head_raw;
  tag_t            head;
  tag_t            push_tag;
  logic            grant_ok;
  logic            sel;
  logic            beat;
  logic            head_rdy;

`ifndef LN_ARB_FIXED_PRIO_EN
  logic            last_grant;
`endif

  assign tag_full = (tag_cnt == CW'(TAG_DEPTH));
  // Gated by rst_n so the request handshakes read 0 while reset is held.
  assign grant_ok = rst_n && (state == IDLE) && !tag_full;

  always_comb begin
    sel = req1_vld;
    if (req0_vld && req1_vld) begin
`ifdef LN_ARB_FIXED_PRIO_EN
      sel = 1'b0;
`else
      sel = ~last_grant;
`endif
    end
  end

  assign req0_rdy = grant_ok && req0_vld && !sel;
  assign req1_rdy = grant_ok && req1_vld && sel;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      id_r           <= 1'b0;
      mcif_rd_req_pd <= '0;
`ifndef LN_ARB_FIXED_PRIO_EN
      last_grant     <= 1'b1;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (req0_rdy || req1_rdy) begin
            mcif_rd_req_pd <= sel ? req1_pd : req0_pd;
            id_r           <= sel;
`ifndef LN_ARB_FIXED_PRIO_EN
            last_grant     <= sel;
`endif
            state          <= ISSUE;
          end
        end
        ISSUE: begin
          if (mcif_rd_req_rdy) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign mcif_rd_req_vld = (state == ISSUE);
  assign tag_push        = (state == ISSUE) && mcif_rd_req_rdy;
  assign push_tag        = '{id: id_r, len: mcif_rd_req_pd[PD_W-1:LEN_LSB]};

  ln_arb_tag_fifo #(
    .DEPTH (TAG_DEPTH),
    .W     (TAG_W)
  ) u_tag_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (tag_push),
    .wdata (push_tag),
    .pop   (tag_pop),
    .rdata (head_raw),
    .count (tag_cnt),
    .empty (tag_empty)
  );

  assign head = tag_t'(head_raw);

  // Responses come back in command order, so the head tag alone decides routing.
  assign head_rdy         = head.id ? resp1_rdy : resp0_rdy;
  assign mcif_rd_resp_rdy = !tag_empty && head_rdy;
  assign resp0_vld        = mcif_rd_resp_vld && !tag_empty && !head.id;
  assign resp1_vld        = mcif_rd_resp_vld && !tag_empty && head.id;
  assign resp0_pd         = mcif_rd_resp_pd;
  assign resp1_pd         = mcif_rd_resp_pd;
  assign beat             = mcif_rd_resp_vld && mcif_rd_resp_rdy;
  assign tag_pop          = beat && (beat_cnt == head.len);
  assign mcif_rd_fifo_pop = beat;
  assign busy             = (state == ISSUE) || !tag_empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt <= '0;
    end else if (beat) begin
      beat_cnt <= tag_pop ? '0 : beat_cnt + 1'b1;
    end
  end
endmodule
